// File: rtl/trigger_capture_fifo_if.sv
// Capture stream from trigger_capture_fifo to its consumer.
// Master drives valid and the head fields; slave drives ready.
interface trigger_capture_fifo_if #(
    parameter int POSITION_SIZE  = 32,
    parameter int TIMESTAMP_SIZE = 32
);
    logic                      m_valid;
    logic                      m_ready;
    logic                      m_direction;
    logic [POSITION_SIZE-1:0]  m_position;
    logic [TIMESTAMP_SIZE-1:0] m_timestamp;

    modport master (
        output m_valid, m_direction, m_position, m_timestamp,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_direction, m_position, m_timestamp,
        output m_ready
    );
endinterface

// File: rtl/trigger_capture_fifo.sv
// Time-stamped trigger capture FIFO with FWFT registered output.
// Optional macro TRIG_CAPTURE_ZERO_GATE_EN gates captures on zero_mark_detected.
module trigger_capture_fifo #(
    parameter int POSITION_SIZE  = 32,
    parameter int TIMESTAMP_SIZE = 32,
    parameter int ADDR_WIDTH     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     enable,
    input  logic                     soft_clear,
    input  logic                     trigger_in,
    input  logic                     direction_in,
    input  logic [POSITION_SIZE-1:0] position_in,
    input  logic                     zero_mark_detected,
    trigger_capture_fifo_if.master   m,
    output logic [ADDR_WIDTH:0]      fill_level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);
    localparam int W     = 1 + POSITION_SIZE + TIMESTAMP_SIZE;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [W-1:0]              mem [DEPTH];
    logic [ADDR_WIDTH:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [ADDR_WIDTH:0]       level, level_nxt;
    logic [TIMESTAMP_SIZE-1:0] ts;
    logic [W-1:0]              wdata, rdata;
    logic                      capture, full, empty;
    logic                      pop, push, drop, load;

`ifdef TRIG_CAPTURE_ZERO_GATE_EN
    assign capture = trigger_in && enable && zero_mark_detected;
`else
    logic unused_zero_mark;
    assign unused_zero_mark = zero_mark_detected;
    assign capture = trigger_in && enable;
`endif

    assign level      = wr_ptr - rd_ptr;
    assign fill_level = level;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    assign pop   = m.m_valid && m.m_ready;
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;
    assign wdata = {direction_in, position_in, ts};

    assign rd_nxt    = rd_ptr + (ADDR_WIDTH+1)'(pop);
    assign level_nxt = level + (ADDR_WIDTH+1)'(push)
                             - (ADDR_WIDTH+1)'(pop);

    // Head reg reloads on pop or first push; bypass when the new head is being written now.
    assign load  = (level_nxt != '0) && (pop || empty);
    assign rdata = (level == (ADDR_WIDTH+1)'(pop)) ? wdata
                 : mem[rd_nxt[ADDR_WIDTH-1:0]];

    always_ff @(posedge i_clk) begin
        if (push && !soft_clear)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata;
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ts            <= '0;
            overflow      <= 1'b0;
            drop_count    <= '0;
            m.m_valid     <= 1'b0;
            m.m_direction <= 1'b0;
            m.m_position  <= '0;
            m.m_timestamp <= '0;
        end else if (soft_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ts         <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            m.m_valid  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_nxt;
            m.m_valid <= (level_nxt != '0);
            if (load)
                {m.m_direction, m.m_position, m.m_timestamp} <= rdata;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 1'b1;
            end
            if (enable)
                ts <= ts + 1'b1;
        end
    end
endmodule

// File: tb/tb_trigger_capture_fifo.sv
// Randomized self-checking bench for trigger_capture_fifo.
// Reference model: a queue of captured entries plus counters.
module tb_trigger_capture_fifo;
    localparam int P  = 32;
    localparam int T  = 32;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic         dir;
        logic [P-1:0] pos;
        logic [T-1:0] ts;
    } ent_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          enable = 0;
    logic          soft_clear = 0;
    logic          trigger_in = 0;
    logic          direction_in = 0;
    logic [P-1:0]  position_in = '0;
    logic          zero_mark = 0;
    logic [AW:0]   fill_level;
    logic          overflow;
    logic [15:0]   drop_count;

    trigger_capture_fifo_if #(.POSITION_SIZE(P), .TIMESTAMP_SIZE(T)) mif ();

    trigger_capture_fifo #(
        .POSITION_SIZE(P), .TIMESTAMP_SIZE(T), .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk),
        .i_aresetn(rst_n),
        .enable(enable),
        .soft_clear(soft_clear),
        .trigger_in(trigger_in),
        .direction_in(direction_in),
        .position_in(position_in),
        .zero_mark_detected(zero_mark),
        .m(mif),
        .fill_level(fill_level),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    logic [T-1:0] mts = '0;
    logic        movf = 0;
    int          mdrops = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(mif.m_valid), 64'(q.size() != 0));
        chk("fill", 64'(fill_level), 64'(q.size()));
        chk("ovf", 64'(overflow), 64'(movf));
        chk("drops", 64'(drop_count), 64'(mdrops));
        if (q.size() != 0) begin
            chk("dir", 64'(mif.m_direction), 64'(q[0].dir));
            chk("pos", 64'(mif.m_position), 64'(q[0].pos));
            chk("ts", 64'(mif.m_timestamp), 64'(q[0].ts));
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic trig,
                        input logic rdy, input logic dir, input logic [P-1:0] pos);
        bit   pop, cap;
        ent_t e;
        enable = en; soft_clear = clr; trigger_in = trig;
        mif.m_ready = rdy; direction_in = dir; position_in = pos;
        if (clr) begin
            q.delete(); mts = '0; movf = 0; mdrops = 0;
        end else begin
            pop = (q.size() != 0) && rdy;
            cap = trig && en;
`ifdef TRIG_CAPTURE_ZERO_GATE_EN
            cap = cap && zero_mark;
`endif
            if (cap) begin
                if (q.size() < DEPTH || pop) begin
                    e.dir = dir; e.pos = pos; e.ts = mts;
                    q.push_back(e);
                end else begin
                    movf = 1;
                    if (mdrops < 65535) mdrops++;
                end
            end
            if (pop) void'(q.pop_front());
            if (en) mts = mts + 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rstep(input logic en, input logic clr, input logic trig,
                         input logic rdy);
        step(en, clr, trig, rdy, 1'($urandom), $urandom);
    endtask

    logic [P-1:0] p3;
    logic [T-1:0] t5;
    int guard;

    initial begin
        mif.m_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(mif.m_valid), 0);
        chk("rst_fill", 64'(fill_level), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_drops", 64'(drop_count), 0);
        chk("rst_pos", 64'(mif.m_position), 0);
        chk("rst_ts", 64'(mif.m_timestamp), 0);
        chk("rst_dir", 64'(mif.m_direction), 0);
        rst_n = 1;
        zero_mark = 1;

        guard = 0;
        while (mts != 10 && guard < 64) begin
            rstep(1, 0, 0, 0);
            guard++;
        end
        chk("t1_reach", 64'(mts), 10);
        step(1, 0, 1, 0, 1'b1, 32'h0001_0005);
        chk("t1_ts", 64'(mif.m_timestamp), 10);
        chk("t1_pos", 64'(mif.m_position), 64'h0001_0005);
        chk("t1_dir", 64'(mif.m_direction), 1);
        chk("t1_fill", 64'(fill_level), 1);
        rstep(1, 0, 0, 1);

        for (int i = 0; i < 17; i++) rstep(1, 0, 1, 0);
        chk("t2_fill", 64'(fill_level), 16);
        chk("t2_ovf", 64'(overflow), 1);
        chk("t2_drops", 64'(drop_count), 1);
        for (int i = 0; i < 16; i++) rstep(1, 0, 0, 1);
        chk("t2_empty", 64'(mif.m_valid), 0);

        for (int i = 0; i < 16; i++) rstep(1, 0, 1, 0);
        p3 = $urandom;
        step(1, 0, 1, 1, 1'b0, p3);
        chk("t3_fill", 64'(fill_level), 16);
        chk("t3_drops", 64'(drop_count), 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t3_last", 64'(mif.m_position), 64'(p3));
            rstep(1, 0, 0, 1);
        end

        for (int i = 0; i < 3; i++) rstep(1, 0, 1, 0);
        rstep(1, 1, 1, 1);
        chk("t4_fill", 64'(fill_level), 0);
        chk("t4_valid", 64'(mif.m_valid), 0);
        chk("t4_ovf", 64'(overflow), 0);
        rstep(1, 0, 1, 0);
        chk("t4_ts", 64'(mif.m_timestamp), 0);
        rstep(1, 0, 0, 1);

        repeat (7) rstep(1, 0, 0, 0);
        t5 = mts;
        repeat (5) rstep(0, 0, 1, 0);
        chk("t5_fill", 64'(fill_level), 0);
        rstep(1, 0, 1, 0);
        chk("t5_ts", 64'(mif.m_timestamp), 64'(t5));
        rstep(1, 0, 0, 1);

`ifdef TRIG_CAPTURE_ZERO_GATE_EN
        rstep(1, 1, 0, 0);
        zero_mark = 0;
        repeat (4) rstep(1, 0, 1, 0);
        chk("t6_fill", 64'(fill_level), 0);
        chk("t6_drops", 64'(drop_count), 0);
        zero_mark = 1;
        rstep(1, 0, 1, 0);
        chk("t6_cap", 64'(fill_level), 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            zero_mark = ($urandom % 4) != 0;
            rstep(($urandom % 8) != 0, ($urandom % 97) == 0,
                  ($urandom % 3) == 0,
                  ((i / 200) % 2 == 0) ? (($urandom % 4) == 0)
                                       : (($urandom % 4) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trigger_capture_fifo.md
Name: trigger_capture_fifo

Overview:
Downstream consumer of the quadrature decoder. On every decoder trigger pulse it captures the absolute position, the direction and a free-running timestamp into a FIFO. Software or the next processing stage drains the FIFO over a valid/ready stream. This gives a lossless, time-stamped record of each delta-section crossing, with explicit overflow reporting.

Parameters:
POSITION_SIZE, 32, width of captured absolute position; must match the decoder.
TIMESTAMP_SIZE, 32, width of the free-running timestamp counter, in clock cycles.
ADDR_WIDTH, 4, FIFO depth is 2**ADDR_WIDTH entries.

Ports:
i_clk  in  1  system clock, the single clock of the block.
i_aresetn  in  1  asynchronous active-low reset.
enable  in  1  capture and timestamp enable.
soft_clear  in  1  synchronous clear of FIFO, flags and timestamp.
trigger_in  in  1  one-clk trigger pulse from the decoder.
direction_in  in  1  decoder direction; 1 = positive.
position_in  in  POSITION_SIZE  decoder absolute position.
zero_mark_detected  in  1  decoder zero-mark-found flag.
m_valid  out  1  head entry valid.
m_ready  in  1  consumer accepts the head entry.
m_direction  out  1  head entry direction.
m_position  out  POSITION_SIZE  head entry position.
m_timestamp  out  TIMESTAMP_SIZE  head entry timestamp.
fill_level  out  ADDR_WIDTH+1  number of stored entries, 0..2**ADDR_WIDTH.
overflow  out  1  sticky flag: at least one capture was dropped.
drop_count  out  16  dropped captures, saturating at 0xFFFF.

Behaviour:
- Reset (asynchronous, active-low):
  - Clears FIFO pointers, timestamp, overflow and drop_count.
  - m_valid=0, fill_level=0; m_direction, m_position and m_timestamp all 0.
- Timestamp:
  - Increments by 1 every clk while enable=1; wraps modulo 2**TIMESTAMP_SIZE.
  - Held while enable=0.
- Capture condition:
  - trigger_in=1 and enable=1 (plus the gate, see Optional Feature).
  - Entry = {direction_in, position_in, timestamp}, using the timestamp value of the trigger cycle, before that cycle's increment.
- Push/pop:
  - Pop occurs when m_valid and m_ready are both 1 on a rising edge.
  - Push into a non-full FIFO is always accepted.
  - Push when full with a simultaneous pop: accepted, fill_level unchanged.
  - Push when full without a pop: entry dropped, overflow set to 1, drop_count incremented (saturating).
- Output path:
  - First-word-fall-through with registered outputs.
  - A push into an empty FIFO makes m_valid=1 and presents the entry on the next clk (latency 1).
  - m_* fields stay stable while m_valid=1 and m_ready=0.
  - After a pop, the next entry appears in the following cycle with no bubble; m_valid stays 1 if entries remain.
  - Read side works regardless of enable.
- fill_level:
  - Reflects the registered state after each edge.
  - Push+pop in the same cycle leaves it unchanged.
- soft_clear (synchronous, highest priority):
  - Empties the FIFO, sets m_valid=0, clears overflow, drop_count and timestamp.
  - A trigger or pop in the same cycle is ignored.
- Pointers: binary, ADDR_WIDTH+1 bits, wrap naturally; full/empty decided by the MSB compare.
- Storage: inferable as simple dual-port RAM (one write port, one read port).

Optional Feature:
Macro: TRIG_CAPTURE_ZERO_GATE_EN.
- Defined: captures are accepted only while zero_mark_detected=1. Triggers before the first zero mark are discarded silently and do not count as drops.
- Undefined: zero_mark_detected is ignored and all enabled triggers are captured.

Test Plan:
1. Reset, enable=1, trigger at timestamp 10 with position 0x00010005, direction 1 -> next clk m_valid=1, m_timestamp=10, m_position=0x00010005, m_direction=1, fill_level=1.
2. Hold m_ready=0, issue 17 triggers with ADDR_WIDTH=4 -> fill_level=16, overflow=1, drop_count=1; then drain with m_ready=1 -> 16 entries in order, m_valid=0 after the last pop.
3. FIFO full, trigger and pop in the same cycle -> no drop, fill_level stays 16, the new entry appears last.
4. 3 entries stored, soft_clear together with a trigger -> fill_level=0, m_valid=0, overflow=0, next-cycle timestamp=0.
5. enable=0 for 5 clks with triggers -> no captures, timestamp unchanged; re-enable -> counting resumes from the held value.
6. TRIG_CAPTURE_ZERO_GATE_EN defined, triggers with zero_mark_detected=0 -> no entries, drop_count=0; after zero_mark_detected=1 a trigger is captured.
